// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - start/busy/done request bus of the nibble-serial adder
//
// Carries one operand request and its result between the controlling logic
// (master) and nibble_serial_adder (slave).
//   start       request, sampled by the adder only while idle
//   op_a, op_b  W-bit operands, W = 4*NIBBLES
//   c_in        carry-in of the whole addition
//   busy        high while nibbles are being summed
//   done        one-cycle pulse, result valid
//   sum, c_out  registered result, held until the next completed add
//   ovf         signed overflow, present only with NIBBLE_SERIAL_ADDER_OVERFLOW_EN
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    logic         ovf;

    modport master (output start, op_a, op_b, c_in, input busy, done, sum, c_out, ovf);
    modport slave  (input start, op_a, op_b, c_in, output busy, done, sum, c_out, ovf);
`else
    modport master (output start, op_a, op_b, c_in, input busy, done, sum, c_out);
    modport slave  (input start, op_a, op_b, c_in, output busy, done, sum, c_out);
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - wide adder sequenced one nibble per clock over an external 4-bit adder
//
// Feeds an external combinational FourBitAdder one nibble per cycle, LSB
// nibble first, keeping the ripple carry in a register between nibbles.
// Optional macro: NIBBLE_SERIAL_ADDER_OVERFLOW_EN adds bus.ovf (signed overflow).
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   bus       nibble_serial_adder_if.slave: start/op_a/op_b/c_in in,
//             busy/done/sum/c_out(/ovf) out
//   add_a     nibble of A to the FourBitAdder (0 outside RUN)
//   add_b     nibble of B to the FourBitAdder (0 outside RUN)
//   add_cin   carry into the FourBitAdder (0 outside RUN)
//   add_s     sum nibble from the FourBitAdder
//   add_cout  carry out of the FourBitAdder
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    nibble_serial_adder_if.slave     bus,
    output logic [3:0]               add_a,
    output logic [3:0]               add_b,
    output logic                     add_cin,
    input  logic [3:0]               add_s,
    input  logic                     add_cout
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     partial;
    logic [W-1:0]     merged;
    logic [W-1:0]     sum_reg;
    logic             carry;
    logic             c_out_reg;
    logic [IDX_W-1:0] idx;
    logic             last_nibble;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    logic             ovf_reg;
`endif

    assign last_nibble = (idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (bus.start) state_next = S_RUN;
            S_RUN:   if (last_nibble) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Nibble select toward the adder. merged is the partial word with the
    // nibble currently being summed patched in, so the final edge can load
    // the complete result into sum in the same cycle.
    always_comb begin
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        merged  = partial;
        if (state == S_RUN) begin
            add_cin = carry;
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx == IDX_W'(i)) begin
                    add_a          = a_reg[4*i +: 4];
                    add_b          = b_reg[4*i +: 4];
                    merged[4*i +: 4] = add_s;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            partial   <= '0;
            sum_reg   <= '0;
            carry     <= 1'b0;
            c_out_reg <= 1'b0;
            idx       <= '0;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_reg   <= bus.op_a;
                        b_reg   <= bus.op_b;
                        carry   <= bus.c_in;
                        partial <= '0;
                        idx     <= '0;
                    end
                end
                S_RUN: begin
                    partial <= merged;
                    if (last_nibble) begin
                        // idx stays at the last nibble; it never wraps
                        sum_reg   <= merged;
                        c_out_reg <= add_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
                        ovf_reg   <= (a_reg[W-1] == b_reg[W-1]) && (merged[W-1] != a_reg[W-1]);
`endif
                    end else begin
                        carry <= add_cout;
                        idx   <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state == S_RUN);
    assign bus.done  = (state == S_DONE);
    assign bus.sum   = sum_reg;
    assign bus.c_out = c_out_reg;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    assign bus.ovf   = ovf_reg;
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_cin;
    logic [3:0] add_s;
    logic       add_cout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] obs_a[$];
    logic [3:0] obs_b[$];
    logic       obs_cin[$];
    logic       sum_moved;
    logic       idle_leak;

    always #5 clk = ~clk;

    nibble_serial_adder_if #(.NIBBLES(N)) bus ();

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    // FourBitAdder stand-in
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    function automatic logic [W-1:0] pack4(input logic [3:0] q[$]);
        logic [W-1:0] v = '0;
        for (int i = 0; i < q.size() && i < N; i++) v[4*i +: 4] = q[i];
        return v;
    endfunction

    function automatic logic [N-1:0] pack1(input logic q[$]);
        logic [N-1:0] v = '0;
        for (int i = 0; i < q.size() && i < N; i++) v[i] = q[i];
        return v;
    endfunction

    // Carry entering each nibble, straight from the arithmetic definition
    function automatic logic [N-1:0] model_cins(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [N-1:0] v;
        longint unsigned m, t;
        for (int i = 0; i < N; i++) begin
            m = (64'd1 << (4*i)) - 1;
            t = (longint'(a) & m) + (longint'(b) & m) + longint'(cin);
            v[i] = t[4*i];
        end
        return v;
    endfunction

    // Issues one request starting in the current cycle (#1 after an edge)
    // and records what the DUT does until it is idle again after done.
    task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int inject_c, output int lat, output int nbusy,
                          output int ndone, output bit timeout);
        logic [W-1:0] sum0;
        obs_a.delete();
        obs_b.delete();
        obs_cin.delete();
        sum_moved = 1'b0;
        idle_leak = 1'b0;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.c_in  = cin;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        sum0    = bus.sum;
        lat     = 0;
        nbusy   = 0;
        ndone   = 0;
        timeout = 1'b1;
        for (int c = 1; c <= 4*N + 20; c++) begin
            if (inject_c != 0 && c == inject_c) begin
                bus.op_a  = '1;
                bus.op_b  = '1;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy) begin
                nbusy++;
                obs_a.push_back(add_a);
                obs_b.push_back(add_b);
                obs_cin.push_back(add_cin);
                if (bus.sum !== sum0) sum_moved = 1'b1;
            end else if (add_a !== 4'd0 || add_b !== 4'd0 || add_cin !== 1'b0) begin
                idle_leak = 1'b1;
            end
            if (bus.done) begin
                ndone++;
                if (lat == 0) lat = c;
            end
            if (ndone > 0 && !bus.busy && !bus.done) begin
                timeout = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.c_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.c_out} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got busy/done/c_out=%b required 000", {bus.busy, bus.done, bus.c_out});
        end
        n_checks++;
        if (bus.sum !== '0) begin
            n_fail++; $display("FAIL reset_sum: got %h required 0000", bus.sum);
        end
        n_checks++;
        if ({add_a, add_b, add_cin} !== 9'd0) begin
            n_fail++; $display("FAIL reset_adder_drive: got %h required 000", {add_a, add_b, add_cin});
        end
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
        n_checks++;
        if (bus.ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_ovf: got %b required 0", bus.ovf);
        end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int lat, nbusy, ndone;
        bit to;
        do_txn(16'h0007, 16'h0003, 1'b0, 0, lat, nbusy, ndone, to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: no done within budget"); end
        n_checks++;
        if (lat != N + 1) begin n_fail++; $display("FAIL basic_latency: got %0d required %0d", lat, N + 1); end
        n_checks++;
        if (nbusy != N) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d required %0d", nbusy, N); end
        n_checks++;
        if (ndone != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d required 1", ndone); end
        n_checks++;
        if ({bus.c_out, bus.sum} !== 17'h0000A) begin
            n_fail++; $display("FAIL basic_result: got c_out=%b sum=%h required c_out=0 sum=000a", bus.c_out, bus.sum);
        end
        n_checks++;
        if (sum_moved !== 1'b0) begin n_fail++; $display("FAIL basic_sum_hold: got sum change during RUN required none"); end
        n_checks++;
        if (idle_leak !== 1'b0) begin n_fail++; $display("FAIL basic_idle_drive: got nonzero adder inputs outside RUN required 0"); end
    endtask

    task automatic test_ripple;
        int lat, nbusy, ndone;
        bit to;
        do_txn(16'hFFFF, 16'h0001, 1'b0, 0, lat, nbusy, ndone, to);
        n_checks++;
        if ({bus.c_out, bus.sum} !== 17'h10000) begin
            n_fail++; $display("FAIL ripple_result: got c_out=%b sum=%h required c_out=1 sum=0000", bus.c_out, bus.sum);
        end
        n_checks++;
        if (obs_cin.size() != N || pack1(obs_cin) !== 4'b1110) begin
            n_fail++; $display("FAIL ripple_add_cin: got %0d cycles bits=%b required 4 cycles bits(msb first)=1110", obs_cin.size(), pack1(obs_cin));
        end
    endtask

    task automatic test_nibble_seq;
        int lat, nbusy, ndone;
        bit to;
        do_txn(16'h0F0F, 16'h00F1, 1'b1, 0, lat, nbusy, ndone, to);
        n_checks++;
        if ({bus.c_out, bus.sum} !== 17'h01001) begin
            n_fail++; $display("FAIL seq_result: got c_out=%b sum=%h required c_out=0 sum=1001", bus.c_out, bus.sum);
        end
        n_checks++;
        if (pack4(obs_a) !== 16'h0F0F) begin
            n_fail++; $display("FAIL seq_add_a: got nibbles(msb first)=%h required 0f0f", pack4(obs_a));
        end
        n_checks++;
        if (pack4(obs_b) !== 16'h00F1) begin
            n_fail++; $display("FAIL seq_add_b: got nibbles(msb first)=%h required 00f1", pack4(obs_b));
        end
    endtask

    task automatic test_start_ignored;
        int lat, nbusy, ndone;
        bit to;
        do_txn(16'h1234, 16'h1111, 1'b0, 2, lat, nbusy, ndone, to);
        n_checks++;
        if ({bus.c_out, bus.sum} !== 17'h02345) begin
            n_fail++; $display("FAIL busy_start_result: got c_out=%b sum=%h required c_out=0 sum=2345", bus.c_out, bus.sum);
        end
        n_checks++;
        if (ndone != 1 || nbusy != N) begin
            n_fail++; $display("FAIL busy_start_pulses: got done=%0d busy=%0d required done=1 busy=%0d", ndone, nbusy, N);
        end
    endtask

    task automatic test_reset_mid;
        int lat, nbusy, ndone, spurious;
        bit to;
        bus.op_a  = 16'hAAAA;
        bus.op_b  = 16'h5555;
        bus.c_in  = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midreset_prebusy: got busy=%b required 1", bus.busy); end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.c_out} !== 3'b000 || bus.sum !== '0) begin
            n_fail++; $display("FAIL midreset_clear: got busy/done/c_out=%b sum=%h required 000 sum=0000", {bus.busy, bus.done, bus.c_out}, bus.sum);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        spurious = 0;
        for (int c = 0; c < 2*N + 4; c++) begin
            if (bus.done || bus.busy) spurious++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (spurious != 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d active cycles required 0", spurious); end
        do_txn(16'h0002, 16'h0002, 1'b0, 0, lat, nbusy, ndone, to);
        n_checks++;
        if ({bus.c_out, bus.sum} !== 17'h00004 || to) begin
            n_fail++; $display("FAIL midreset_recover: got c_out=%b sum=%h required c_out=0 sum=0004", bus.c_out, bus.sum);
        end
    endtask

    task automatic test_random;
        int lat, nbusy, ndone;
        bit to;
        logic [W-1:0] a, b;
        logic cin;
        logic [W:0] exp_full;
        for (int t = 0; t < 16; t++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            if (t == 0) begin a = '1; b = '1; cin = 1'b1; end
            exp_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            do_txn(a, b, cin, 0, lat, nbusy, ndone, to);
            n_checks++;
            if ({bus.c_out, bus.sum} !== exp_full) begin
                n_fail++; $display("FAIL rand_result[%0d]: %h+%h+%b got %h required %h", t, a, b, cin, {bus.c_out, bus.sum}, exp_full);
            end
            n_checks++;
            if (pack1(obs_cin) !== model_cins(a, b, cin) || pack4(obs_a) !== a || pack4(obs_b) !== b) begin
                n_fail++; $display("FAIL rand_nibbles[%0d]: got cin=%b a=%h b=%h required cin=%b a=%h b=%h", t, pack1(obs_cin), pack4(obs_a), pack4(obs_b), model_cins(a, b, cin), a, b);
            end
            n_checks++;
            if (lat != N + 1 || nbusy != N || ndone != 1 || sum_moved || idle_leak) begin
                n_fail++; $display("FAIL rand_timing[%0d]: got lat=%0d busy=%0d done=%0d moved=%b leak=%b required %0d/%0d/1/0/0", t, lat, nbusy, ndone, sum_moved, idle_leak, N + 1, N);
            end
        end
    endtask

    task automatic test_back_to_back;
        int done_at[$];
        logic [W-1:0] a, b;
        logic [W:0] exp_full;
        int bad_sum;
        a = W'($urandom);
        b = W'($urandom);
        exp_full = {1'b0, a} + {1'b0, b};
        bad_sum = 0;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.c_in  = 1'b0;
        bus.start = 1'b1;
        for (int c = 1; c <= 3 * (N + 2); c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                done_at.push_back(c);
                if ({bus.c_out, bus.sum} !== exp_full) bad_sum++;
            end
        end
        bus.start = 1'b0;
        n_checks++;
        if (done_at.size() != 3) begin
            n_fail++; $display("FAIL b2b_count: got %0d done pulses required 3", done_at.size());
        end else begin
            n_checks++;
            if (done_at[0] != N + 1 || done_at[1] - done_at[0] != N + 2 || done_at[2] - done_at[1] != N + 2) begin
                n_fail++; $display("FAIL b2b_spacing: got %0d,%0d,%0d required %0d,%0d,%0d", done_at[0], done_at[1], done_at[2], N + 1, 2*N + 3, 3*N + 5);
            end
        end
        n_checks++;
        if (bad_sum != 0) begin n_fail++; $display("FAIL b2b_result: got %0d wrong results required 0", bad_sum); end
        repeat (2) @(posedge clk);
        #1;
    endtask

`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    task automatic test_ovf;
        int lat, nbusy, ndone;
        bit to;
        logic [W-1:0] va[3] = '{16'h7FFF, 16'h8000, 16'h0002};
        logic [W-1:0] vb[3] = '{16'h0001, 16'h8000, 16'h0005};
        logic [W:0]   exp_full;
        logic         exp_ovf;
        for (int t = 0; t < 3; t++) begin
            exp_full = {1'b0, va[t]} + {1'b0, vb[t]};
            exp_ovf  = (va[t][W-1] == vb[t][W-1]) && (exp_full[W-1] != va[t][W-1]);
            do_txn(va[t], vb[t], 1'b0, 0, lat, nbusy, ndone, to);
            n_checks++;
            if ({bus.c_out, bus.sum} !== exp_full || bus.ovf !== exp_ovf) begin
                n_fail++; $display("FAIL ovf[%0d]: got %h ovf=%b required %h ovf=%b", t, {bus.c_out, bus.sum}, bus.ovf, exp_full, exp_ovf);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_ripple();
        test_nibble_seq();
        test_start_ignored();
        test_reset_mid();
        test_random();
        test_back_to_back();
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
        test_ovf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Sequencing stage wrapped around the existing combinational FourBitAdder.
- Adds two wide operands one nibble per clock, LSB nibble first.
- Drives the adder's A/B/C_in and captures its S/C_out, keeping the ripple carry in a register between nibbles.
- Lets the team build 8/16/32-bit adders from the verified 4-bit datapath, with a start/busy/done handshake toward the controlling logic.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op_a  input  W  operand A; latched when start is accepted
- op_b  input  W  operand B; latched when start is accepted
- c_in  input  1  carry-in; latched when start is accepted
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when the result is valid
- sum  output  W  result register
- c_out  output  1  final carry
- add_a  output  4  to FourBitAdder A
- add_b  output  4  to FourBitAdder B
- add_cin  output  1  to FourBitAdder C_in
- add_s  input  4  from FourBitAdder S
- add_cout  input  1  from FourBitAdder C_out

Behaviour:
- Reset: rst is asynchronous and active-high. Asserting it, including mid-operation, forces:
  - state = IDLE
  - busy = 0, done = 0, sum = 0, c_out = 0
  - internal a_reg, b_reg, carry, idx and partial-sum registers = 0
  - any transaction in progress is abandoned; no done pulse is produced.
- States: IDLE, RUN, DONE; state is registered.
- IDLE:
  - start=1 at a clock edge latches op_a, op_b and c_in (as carry), sets idx=0 and goes to RUN.
  - start=0 stays in IDLE.
- RUN, one nibble per cycle:
  - add_a = a_reg[4*idx+3:4*idx], add_b = b_reg[4*idx+3:4*idx], add_cin = carry; all combinational from registers.
  - At the clock edge: partial[4*idx+3:4*idx] <= add_s, carry <= add_cout, idx <= idx+1.
  - When idx == NIBBLES-1, the edge instead moves to DONE, sum <= the full partial word (including the final nibble) and c_out <= add_cout.
- DONE:
  - done=1 for exactly one cycle.
  - The next edge returns to IDLE unconditionally.
  - start during DONE is ignored.
- busy = 1 exactly in RUN (NIBBLES cycles).
- Outputs while idle: add_a, add_b, add_cin = 0 outside RUN.
- Latency: start sampled at edge k; done is high during cycle k+NIBBLES+1. Throughput is one add per NIBBLES+2 cycles.
- Result hold: sum and c_out update only on the RUN→DONE edge and hold until the next completed transaction. Intermediate nibbles never appear on sum.
- start while busy or in DONE has no effect; operands are not re-latched.
- Arithmetic is unsigned modulo 2^W; c_out is the carry out of bit W-1.
- NIBBLES=1: exactly one RUN cycle, identical in result to a single FourBitAdder evaluation.
- idx width = clog2(NIBBLES), minimum 1 bit; it never wraps past NIBBLES-1.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_OVERFLOW_EN
- Defined:
  - Extra output ovf (1 bit), reset 0, updated on the RUN→DONE edge alongside sum.
  - ovf = (a_reg[W-1] == b_reg[W-1]) && (final sum[W-1] != a_reg[W-1]), i.e. signed two's-complement overflow.
  - Held with sum.
- Undefined:
  - Port ovf does not exist; no related logic is present.

Test Plan (NIBBLES=4, FourBitAdder instantiated as the datapath):
- op_a=0x0007, op_b=0x0003, c_in=0, start pulse -> busy high 4 cycles, done pulse on cycle 5 after the start edge, sum=0x000A, c_out=0.
- op_a=0xFFFF, op_b=0x0001, c_in=0 -> carry ripples through all nibbles; sum=0x0000, c_out=1; add_cin observed as 0,1,1,1 across the RUN cycles.
- op_a=0x0F0F, op_b=0x00F1, c_in=1 -> sum=0x1001, c_out=0; add_a sequence F,0,F,0 and add_b sequence 1,F,0,0.
- Start 0x1234+0x1111, then pulse start with 0xFFFF/0xFFFF during RUN cycle 2 -> second start ignored; sum=0x2345, c_out=0, exactly one done pulse.
- Start 0xAAAA+0x5555, assert rst during RUN cycle 3 -> busy, done, sum, c_out immediately 0, no done pulse. After release, 0x0002+0x0002 -> sum=0x0004.
- With NIBBLE_SERIAL_ADDER_OVERFLOW_EN:
  - 0x7FFF+0x0001 -> sum=0x8000, c_out=0, ovf=1.
  - 0x8000+0x8000 -> sum=0x0000, c_out=1, ovf=1.
  - 0x0002+0x0005 -> ovf=0.
